// File: rtl/mem_port_arbiter_pkg.sv
// rtl/mem_port_arbiter_pkg.sv - shared types for the unified memory port arbiter
package mem_port_arbiter_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_I_REQ  = 3'd1,
        ST_I_WAIT = 3'd2,
        ST_D_REQ  = 3'd3,
        ST_D_WAIT = 3'd4,
        ST_RESP   = 3'd5
    } arb_state_t;

    function automatic int strb_width(input int data_w);
        return data_w / 8;
    endfunction

endpackage

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - fetch/data arbiter for a single-ported memory bus
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int ADDR_W     = 64,
    parameter int DATA_W     = 64,
    parameter int STARVE_MAX = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          if_req,
    input  logic [ADDR_W-1:0]             if_addr,
    output logic [DATA_W-1:0]             if_rdata,
    output logic                          if_done,
    input  logic                          d_req,
    input  logic                          d_we,
    input  logic [ADDR_W-1:0]             d_addr,
    input  logic [DATA_W-1:0]             d_wdata,
    input  logic [strb_width(DATA_W)-1:0] d_wstrb,
    output logic [DATA_W-1:0]             d_rdata,
    output logic                          d_done,
    output logic                          mem_req,
    output logic                          mem_we,
    output logic [ADDR_W-1:0]             mem_addr,
    output logic [DATA_W-1:0]             mem_wdata,
    output logic [strb_width(DATA_W)-1:0] mem_wstrb,
    input  logic                          mem_gnt,
    input  logic                          mem_rvalid,
    input  logic [DATA_W-1:0]             mem_rdata,
    output logic                          stall_if,
    output logic                          stall_mem,
    output logic                          busy
);

    localparam int CNT_W = $clog2(STARVE_MAX + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_MAX);

    arb_state_t       state, state_next;
    logic [CNT_W-1:0] starve_cnt;
    logic             resp_data;
    logic             grant_i, grant_d;

    // Data wins unless fetch has already watched STARVE_MAX data grants go by.
    always_comb begin
        state_next = state;
        grant_i    = 1'b0;
        grant_d    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (d_req && !(if_req && starve_cnt == CNT_MAX)) begin
                    grant_d    = 1'b1;
                    state_next = ST_D_REQ;
                end else if (if_req) begin
                    grant_i    = 1'b1;
                    state_next = ST_I_REQ;
                end
            end
            ST_I_REQ:  if (mem_gnt)    state_next = ST_I_WAIT;
            ST_I_WAIT: if (mem_rvalid) state_next = ST_RESP;
            ST_D_REQ:  if (mem_gnt)    state_next = ST_D_WAIT;
            ST_D_WAIT: if (mem_rvalid) state_next = ST_RESP;
            ST_RESP:   state_next = ST_IDLE;
            default:   state_next = ST_IDLE;
        endcase
    end

    assign if_done   = (state == ST_RESP) && !resp_data;
    assign d_done    = (state == ST_RESP) && resp_data;
    assign stall_if  = if_req & ~if_done;
    assign stall_mem = d_req & ~d_done;
    assign busy      = (state != ST_IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            starve_cnt <= '0;
            resp_data  <= 1'b0;
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            mem_wstrb  <= '0;
            if_rdata   <= '0;
            d_rdata    <= '0;
        end else begin
            state <= state_next;
            if (grant_d) begin
                mem_req   <= 1'b1;
                mem_we    <= d_we;
                mem_addr  <= d_addr;
                mem_wdata <= d_wdata;
                mem_wstrb <= d_wstrb;
                resp_data <= 1'b1;
                if (!if_req)
                    starve_cnt <= '0;
                else if (starve_cnt != CNT_MAX)
                    starve_cnt <= starve_cnt + 1'b1;
            end
            if (grant_i) begin
                mem_req    <= 1'b1;
                mem_we     <= 1'b0;
                mem_addr   <= if_addr;
                mem_wdata  <= '0;
                mem_wstrb  <= '0;
                resp_data  <= 1'b0;
                starve_cnt <= '0;
            end
            if ((state == ST_I_REQ || state == ST_D_REQ) && mem_gnt)
                mem_req <= 1'b0;
            if (state == ST_I_WAIT && mem_rvalid)
                if_rdata <= mem_rdata;
            // A store's rvalid is only an ack, so load data stays as it was.
            if (state == ST_D_WAIT && mem_rvalid && !mem_we)
                d_rdata <= mem_rdata;
        end
    end

endmodule
